icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised, set-associative, read-only instruction cache between the IF stage (PC fetch) and the line-wide instruction main memory.
- Successor to the current direct-mapped cache, adding configurable sets, ways and line size, round-robin replacement, and a clean registered miss FSM.
- Hits return in the same cycle. Misses stall IF via busywait until the line is filled.

Parameters:
ADDR_W, 32, byte address width
NUM_SETS, 8, sets; power of 2, at least 2
NUM_WAYS, 2, ways per set; power of 2, 1..8
LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2
Derived (localparam): OFF_W=log2(LINE_WORDS)+2, IDX_W=log2(NUM_SETS), TAG_W=ADDR_W-IDX_W-OFF_W, LINE_W=32*LINE_WORDS

Ports:
clock  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
read  in  1  fetch request, level
address  in  ADDR_W  byte PC; bits [1:0] ignored
readdata  out  32  instruction word
busywait  out  1  stall to IF
mem_read  out  1  main-memory line read request
mem_address  out  ADDR_W-OFF_W  line address {tag,index}
mem_readdata  in  LINE_W  returned line, word 0 in bits [31:0]
mem_busywait  in  1  main memory busy

Behaviour:
- Address split: tag=address[ADDR_W-1:IDX_W+OFF_W], index=address[IDX_W+OFF_W-1:OFF_W], word=address[OFF_W-1:2].
- Storage per set and way: valid, tag, line. Per set: round-robin victim pointer of width log2(NUM_WAYS), zero-width when NUM_WAYS=1.
- Reset (async): state=IDLE; all valid=0; all victim pointers=0; mem_read=0; mem_address=0; busywait=0 while read=0; readdata=0. Data and tag arrays are not cleared.
- Hit: in IDLE with read=1 and any way valid with matching tag. busywait=0 and readdata=that way's word, both combinational in the same cycle. Zero-cycle latency.
- Miss: in IDLE with read=1 and no hit:
  - busywait=1 combinationally.
  - Next edge: state becomes MEM_READ; register miss tag, index and victim way.
  - Victim = lowest-index invalid way in the set, else the set's victim pointer.
- MEM_READ:
  - mem_read=1; mem_address = registered {tag,index}, held constant; busywait=1.
  - Leave on the first edge with mem_busywait=0 and go to FILL; capture mem_readdata at that edge.
- FILL (one cycle):
  - Write line, tag and valid=1 into the registered set and victim way.
  - If victim came from the pointer, pointer increments modulo NUM_WAYS; an invalid-way fill leaves the pointer unchanged.
  - mem_read=0; busywait=1.
  - Next edge goes to IDLE, where the lookup re-evaluates and hits.
- Miss latency = mem latency + 2 cycles of busywait after mem_busywait falls: one edge to FILL, one edge to IDLE.
- read=0 in IDLE: busywait=0; readdata holds its last value (registered hold of the last returned word); no state change.
- address or read changing during MEM_READ or FILL is ignored; the registered miss is completed and the fill is not cancelled. On return to IDLE the current address is looked up afresh.
- Same tag present in two ways is impossible by construction: a fill only occurs after a miss.
- Reset asserted mid-miss: immediate return to IDLE, mem_read=0, all lines invalid. The outstanding memory read is abandoned and memory must tolerate the request dropping.
- Outputs mem_read and mem_address are driven from registered state only; no combinational path from address.

Optional Feature:
- Macro ICACHE_FLUSH_EN adds input port flush (1 bit), for fence.i.
- With macro: flush=1 sampled in IDLE clears all valid bits and victim pointers at that edge, and busywait=1 for that cycle. flush during MEM_READ is deferred: the fill completes, then the flush is applied on the first IDLE cycle, so the just-filled line is also invalidated.
- Without macro: no flush port; lines are invalidated only by reset.

Decomposition:
- Package icache_pkg:
  - State enum {IDLE, MEM_READ, FILL}.
  - clog2-based width helper functions.
  - Default parameter constants.
- One sub-module icache_victim_sel: per-set round-robin pointer plus a first-invalid priority encoder. Inputs are the valid vector and pointer; output is the victim way.
- Tag compare and word select stay in the top module.

Test Plan:
- Cold miss: reset, read=1, address=0x40, mem latency 3 → mem_read=1, mem_address=0x4 (defaults), busywait high 5 cycles; then readdata=word0 of the line with busywait=0.
- Hit after fill: address=0x44, then 0x4C → busywait=0 the same cycle, readdata=words 1 and 3, mem_read stays 0.
- Associativity and replacement (defaults): fill 0x000 then 0x080 into set 0, both hit. Then 0x100 misses → evicts way0 (pointer 0→1) and 0x000 misses; then 0x080 evicted next.
- Address change mid-miss: miss on 0x40, switch address to 0x200 during MEM_READ → line 0x40 filled, then a new miss issued for 0x200.
- Reset mid-miss: assert reset during MEM_READ → mem_read=0 asynchronously; re-access of 0x40 misses.
- ICACHE_FLUSH_EN: fill 0x40, pulse flush in IDLE → next access to 0x40 misses; a flush during MEM_READ causes a miss on re-access after the fill.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types, default sizes and width helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        FILL     = 2'd2
    } state_e;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_NUM_SETS   = 8;
    localparam int DEF_NUM_WAYS   = 2;
    localparam int DEF_LINE_WORDS = 4;

    // Index width that never collapses to zero, so a 1-way cache still has a legal vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim choice for one set: lowest invalid way if any, otherwise the round-robin pointer.
module icache_victim_sel
    import icache_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int WAY_W    = clog2_min1(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] valid_i,
    input  logic [WAY_W-1:0]    ptr_i,
    output logic [WAY_W-1:0]    victim_o,
    output logic                from_ptr_o
);

    // Scan from the top so the lowest invalid way is the one left standing.
    always_comb begin
        victim_o   = ptr_i;
        from_ptr_o = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                victim_o   = WAY_W'(w);
                from_ptr_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with a registered IDLE/MEM_READ/FILL miss FSM.
// Define ICACHE_FLUSH_EN to add the flush input (fence.i invalidate-all).
module icache_assoc
    import icache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int NUM_WAYS   = DEF_NUM_WAYS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  read,
    input  logic [ADDR_W-1:0]                     address,
    output logic [31:0]                           readdata,
    output logic                                  busywait,
    output logic                                  mem_read,
    output logic [ADDR_W-off_w(LINE_WORDS)-1:0]   mem_address,
    input  logic [32*LINE_WORDS-1:0]              mem_readdata,
    input  logic                                  mem_busywait
`ifdef ICACHE_FLUSH_EN
    ,
    input  logic                                  flush
`endif
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int WAY_W  = clog2_min1(NUM_WAYS);

    state_e              state_q, state_d;
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [WAY_W-1:0]    ptr_q   [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    miss_tag_q;
    logic [IDX_W-1:0]    miss_idx_q;
    logic [WAY_W-1:0]    miss_way_q;
    logic                miss_from_ptr_q;
    logic [LINE_W-1:0]   fill_line_q;
    logic [31:0]         readdata_q;
    logic                flush_pend_q;

    logic [TAG_W-1:0]  tag_a;
    logic [IDX_W-1:0]  idx_a;
    logic [WORD_W-1:0] word_a;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [31:0]       hit_word;
    logic [WAY_W-1:0]  victim;
    logic              victim_from_ptr;
    logic [WAY_W-1:0]  ptr_fill;
    logic              flush_in;
    logic              do_flush;
    logic              unused_addr_bits;

    assign tag_a            = address[ADDR_W-1 -: TAG_W];
    assign idx_a            = address[OFF_W +: IDX_W];
    assign word_a           = address[2 +: WORD_W];
    assign unused_addr_bits = ^address[1:0];

`ifdef ICACHE_FLUSH_EN
    assign flush_in = flush;
`else
    assign flush_in = 1'b0;
`endif

    // A flush seen mid-miss is held until the fill lands, so the new line is dropped too.
    assign do_flush = (state_q == IDLE) && (flush_in || flush_pend_q);

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx_a][w] && (tag_q[idx_a][w] == tag_a)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_word = data_q[idx_a][hit_way][{word_a, 5'd0} +: 32];
    assign ptr_fill = (NUM_WAYS > 1) ? ptr_q[miss_idx_q] + WAY_W'(1) : '0;

    icache_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
    ) u_victim_sel (
        .valid_i    (valid_q[idx_a]),
        .ptr_i      (ptr_q[idx_a]),
        .victim_o   (victim),
        .from_ptr_o (victim_from_ptr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!do_flush && read && !hit) state_d = MEM_READ;
            MEM_READ: if (!mem_busywait) state_d = FILL;
            FILL:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busywait = 1'b1;
        readdata = readdata_q;
        mem_read = (state_q == MEM_READ);
        if (state_q == IDLE) begin
            busywait = do_flush || (read && !hit);
            if (!do_flush && read && hit) readdata = hit_word;
        end
    end

    assign mem_address = {miss_tag_q, miss_idx_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            miss_tag_q      <= '0;
            miss_idx_q      <= '0;
            miss_way_q      <= '0;
            miss_from_ptr_q <= 1'b0;
            readdata_q      <= '0;
            flush_pend_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && !do_flush && read && hit) readdata_q <= hit_word;
            if (state_q == IDLE && state_d == MEM_READ) begin
                miss_tag_q      <= tag_a;
                miss_idx_q      <= idx_a;
                miss_way_q      <= victim;
                miss_from_ptr_q <= victim_from_ptr;
            end
            if (state_q == FILL) begin
                valid_q[miss_idx_q][miss_way_q] <= 1'b1;
                if (miss_from_ptr_q) ptr_q[miss_idx_q] <= ptr_fill;
            end
            if (state_q != IDLE && flush_in) flush_pend_q <= 1'b1;
            else if (do_flush)               flush_pend_q <= 1'b0;
            if (do_flush) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[s] <= '0;
                    ptr_q[s]   <= '0;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone decide what is live.
    always_ff @(posedge clock) begin
        if (state_q == MEM_READ && !mem_busywait) fill_line_q <= mem_readdata;
        if (state_q == FILL) begin
            data_q[miss_idx_q][miss_way_q] <= fill_line_q;
            tag_q[miss_idx_q][miss_way_q]  <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: scoreboard of expected fetch words checked by a monitor.
module tb_icache_assoc;

    localparam int ADDR_W  = 32;
    localparam int OFF_W   = 4;
    localparam int MA_W    = ADDR_W - OFF_W;
    localparam int LINE_W  = 128;
    localparam int MEM_LAT = 3;
    localparam int MISS_BUSY = MEM_LAT + 2;

    logic              clock;
    logic              reset;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [31:0]       readdata;
    logic              busywait;
    logic              mem_read;
    logic [MA_W-1:0]   mem_address;
    logic [LINE_W-1:0] mem_readdata;
    logic              mem_busywait;
`ifdef ICACHE_FLUSH_EN
    logic              flush;
`endif

    int tests;
    int fails;
    int mem_cnt;
    logic [31:0] exp_q[$];

    icache_assoc dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef ICACHE_FLUSH_EN
        ,
        .flush        (flush)
`endif
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Memory model: every instruction word is a fixed function of its byte address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++)
            mem_readdata[32*i +: 32] = word_of({mem_address, 2'(i), 2'b00});
    end

    always @(posedge clock) begin
        if (!mem_read) mem_cnt <= 0;
        else           mem_cnt <= mem_cnt + 1;
    end
    assign mem_busywait = mem_read && (mem_cnt < MEM_LAT - 1);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: every accepted fetch must return the next queued word.
    always @(negedge clock) begin
        if (!reset && read && !busywait) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL readdata: got %0h with no fetch outstanding", readdata);
            end else begin
                check("readdata", {32'd0, readdata}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks
    task automatic do_reset();
        reset   = 1'b1;
        read    = 1'b0;
        address = '0;
`ifdef ICACHE_FLUSH_EN
        flush   = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_busy, input string name);
        int busy;
        logic seen;
        logic [MA_W-1:0] got_ma;
        busy   = 0;
        seen   = 1'b0;
        got_ma = '0;
        @(posedge clock);
        #1 address = a;
        read = 1'b1;
        exp_q.push_back(word_of(a));
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (!busywait) break;
            busy++;
            if (mem_read && !seen) begin
                seen   = 1'b1;
                got_ma = mem_address;
            end
        end
        check({name, " busy cycles"}, 64'(busy), 64'(exp_busy));
        if (exp_busy == 0) check({name, " mem_read on hit"}, {63'd0, seen}, 64'd0);
        else               check({name, " mem_address"}, 64'(got_ma), 64'(a >> OFF_W));
        @(posedge clock);
        #1 read = 1'b0;
    endtask

    task automatic wait_mem_read(input string name);
        int c;
        c = 0;
        while (!mem_read && c < 60) begin
            @(negedge clock);
            c++;
        end
        check({name, " mem_read raised"}, {63'd0, mem_read}, 64'd1);
    endtask

    initial begin
        int busy;
        int new_reqs;
        logic prev_mr;
        logic [MA_W-1:0] new_ma;
        tests = 0;
        fails = 0;
        do_reset();

        @(negedge clock);
        check("reset readdata", {32'd0, readdata}, 64'd0);
        check("reset busywait", {63'd0, busywait}, 64'd0);
        check("reset mem_read", {63'd0, mem_read}, 64'd0);
        check("reset mem_address", 64'(mem_address), 64'd0);

        // Cold miss, then hits in the same line, then read=0 holds the last word
        fetch(32'h40, MISS_BUSY, "cold 0x40");
        fetch(32'h44, 0, "hit 0x44");
        fetch(32'h4C, 0, "hit 0x4C");
        @(posedge clock);
        #1 address = 32'h44;
        @(negedge clock);
        check("idle hold readdata", {32'd0, readdata}, {32'd0, word_of(32'h4C)});
        check("idle busywait", {63'd0, busywait}, 64'd0);

        // Two-way set 0 with round-robin eviction
        fetch(32'h000, MISS_BUSY, "fill 0x000");
        fetch(32'h080, MISS_BUSY, "fill 0x080");
        fetch(32'h000, 0, "hit 0x000");
        fetch(32'h084, 0, "hit 0x084");
        fetch(32'h100, MISS_BUSY, "evict way0 0x100");
        fetch(32'h088, 0, "0x080 survives");
        fetch(32'h008, MISS_BUSY, "0x000 refetch");
        fetch(32'h104, 0, "0x100 survives");
        fetch(32'h08C, MISS_BUSY, "0x080 refetch");
        fetch(32'h00C, 0, "0x000 survives");
        fetch(32'h100, MISS_BUSY, "0x100 evicted");
        fetch(32'h40, 0, "other set untouched");

        // Address change while the miss is outstanding
        do_reset();
        @(posedge clock);
        #1 address = 32'h40;
        read = 1'b1;
        wait_mem_read("midmiss");
        check("midmiss first mem_address", 64'(mem_address), 64'h4);
        @(posedge clock);
        #1 address = 32'h200;
        exp_q.push_back(word_of(32'h200));
        busy     = 0;
        new_reqs = 0;
        new_ma   = '0;
        prev_mr  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (!busywait) break;
            busy++;
            if (mem_read && !prev_mr) begin
                new_reqs++;
                new_ma = mem_address;
            end
            prev_mr = mem_read;
        end
        check("midmiss new requests", 64'(new_reqs), 64'd1);
        check("midmiss second mem_address", 64'(new_ma), 64'h20);
        @(posedge clock);
        #1 read = 1'b0;
        fetch(32'h48, 0, "midmiss 0x40 filled");

        // Reset during MEM_READ drops the request at once
        do_reset();
        @(posedge clock);
        #1 address = 32'h40;
        read = 1'b1;
        wait_mem_read("rstmiss");
        #3 reset = 1'b1;
        #1;
        check("rstmiss mem_read", {63'd0, mem_read}, 64'd0);
        check("rstmiss mem_address", 64'(mem_address), 64'd0);
        read = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        fetch(32'h40, MISS_BUSY, "rstmiss refetch");

`ifdef ICACHE_FLUSH_EN
        // Flush in IDLE invalidates everything
        fetch(32'h44, 0, "flush pre hit");
        @(posedge clock);
        #1 flush = 1'b1;
        @(negedge clock);
        check("flush busywait", {63'd0, busywait}, 64'd1);
        @(posedge clock);
        #1 flush = 1'b0;
        fetch(32'h40, MISS_BUSY, "after flush");

        // Flush during MEM_READ is applied after the fill
        @(posedge clock);
        #1 address = 32'h300;
        read = 1'b1;
        wait_mem_read("deferred flush");
        @(posedge clock);
        #1 read = 1'b0;
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (!busywait) break;
        end
        fetch(32'h300, MISS_BUSY, "deferred flush refetch");
        fetch(32'h44, MISS_BUSY, "deferred flush other line");
`endif

        repeat (3) @(posedge clock);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
